// File: rtl/matmul_pkg.sv
// Shared types and default geometry for the C = A*B sequencer.
// Matrices live row-major in one word-addressed data memory.
package matmul_pkg;

    localparam int WORD_W      = 32;
    localparam int DEF_N       = 3;
    localparam int DEF_A_BASE  = 0;
    localparam int DEF_B_BASE  = 9;
    localparam int DEF_C_BASE  = 18;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_ACC,
        S_WR,
        S_DONE
    } state_t;

    // Row-major word address of element (row, col) in an n-wide matrix at base.
    function automatic logic [WORD_W-1:0] lin_addr(
        input logic [WORD_W-1:0] base,
        input logic [WORD_W-1:0] row,
        input logic [WORD_W-1:0] col,
        input logic [WORD_W-1:0] n
    );
        return base + row * n + col;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Unsigned multiply-accumulate; product and sum both wrap modulo 2^WORD_W.
// clr has priority over en so a clear and an accumulate never collide.
module mac_unit
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              clr,
    input  logic              en,
    output logic [WORD_W-1:0] acc
);

    logic [WORD_W-1:0] r_acc;
    logic [WORD_W-1:0] w_prod;

    assign w_prod = a * b;
    assign acc    = r_acc;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc + w_prod;
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Drives a single-port data memory to compute C = A*B one element at a time:
// per element N x (read A, read B, accumulate) and then one write of C.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int A_BASE = DEF_A_BASE,
    parameter int B_BASE = DEF_B_BASE,
    parameter int C_BASE = DEF_C_BASE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] address,
    output logic [WORD_W-1:0] write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [WORD_W-1:0] read_data
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t            r_state;
    logic [IDX_W-1:0]  r_i;
    logic [IDX_W-1:0]  r_j;
    logic [IDX_W-1:0]  r_k;
    logic [WORD_W-1:0] r_a_reg;
    logic              r_busy;
    logic              r_done;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [WORD_W-1:0] r_address;

    logic [WORD_W-1:0] w_acc;
    logic              w_mac_clr;
    logic              w_mac_en;
    logic              w_j_wrap;
    logic              w_last_elem;
    logic [IDX_W-1:0]  w_next_i;
    logic [IDX_W-1:0]  w_next_j;
    logic [WORD_W-1:0] w_addr_b;
    logic [WORD_W-1:0] w_addr_c;
    logic [WORD_W-1:0] w_addr_a_knext;
    logic [WORD_W-1:0] w_addr_a_row;

    assign w_j_wrap    = (r_j == IDX_LAST);
    assign w_last_elem = w_j_wrap && (r_i == IDX_LAST);
    assign w_next_j    = w_j_wrap ? '0 : r_j + IDX_ONE;
    assign w_next_i    = w_j_wrap ? r_i + IDX_ONE : r_i;

    // Outputs are registered, so each address is computed for the state being entered.
    assign w_addr_b       = lin_addr(WORD_W'(B_BASE), WORD_W'(r_k), WORD_W'(r_j), WORD_W'(N));
    assign w_addr_c       = lin_addr(WORD_W'(C_BASE), WORD_W'(r_i), WORD_W'(r_j), WORD_W'(N));
    assign w_addr_a_knext = lin_addr(WORD_W'(A_BASE), WORD_W'(r_i), WORD_W'(r_k) + 1, WORD_W'(N));
    assign w_addr_a_row   = lin_addr(WORD_W'(A_BASE), WORD_W'(w_next_i), '0, WORD_W'(N));

    // Accumulator sits at zero while idle and is cleared on the edge that leaves WR.
    assign w_mac_clr = reset || (r_state == S_IDLE) || (r_state == S_WR);
    assign w_mac_en  = (r_state == S_ACC);

    mac_unit u_mac (
        .clk (clock),
        .a   (r_a_reg),
        .b   (read_data),
        .clr (w_mac_clr),
        .en  (w_mac_en),
        .acc (w_acc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_a_reg     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_address   <= '0;
        end else begin
            r_done      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_address   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_i        <= '0;
                        r_j        <= '0;
                        r_k        <= '0;
                        r_state    <= S_RD_A;
                        r_busy     <= 1'b1;
                        r_mem_read <= 1'b1;
                        r_address  <= WORD_W'(A_BASE);
                    end
                end
                S_RD_A: begin
                    r_state    <= S_RD_B;
                    r_mem_read <= 1'b1;
                    r_address  <= w_addr_b;
                end
                S_RD_B: begin
                    r_a_reg <= read_data;
                    r_state <= S_ACC;
                end
                S_ACC: begin
                    if (r_k == IDX_LAST) begin
                        r_state     <= S_WR;
                        r_mem_write <= 1'b1;
                        r_address   <= w_addr_c;
                    end else begin
                        r_k        <= r_k + IDX_ONE;
                        r_state    <= S_RD_A;
                        r_mem_read <= 1'b1;
                        r_address  <= w_addr_a_knext;
                    end
                end
                S_WR: begin
                    r_k <= '0;
                    r_i <= w_next_i;
                    r_j <= w_next_j;
                    if (w_last_elem) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= S_RD_A;
                        r_mem_read <= 1'b1;
                        r_address  <= w_addr_a_row;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;
    assign address    = r_address;
    assign write_data = r_mem_write ? w_acc : '0;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer against a registered-read memory model.
// Each scenario task drives its stimulus and checks hand-computed results inline.
module tb_matmul_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, mem_read, mem_write;
    logic [31:0] address, write_data, read_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    matmul_sequencer #(.N(3), .A_BASE(0), .B_BASE(9), .C_BASE(18)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .address    (address),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .read_data  (read_data)
    );

    // Memory model: one-cycle read latency, loader port for preloading.
    logic [31:0] mem [0:63];
    logic [31:0] rdata = 32'd0;
    logic        ld_en = 1'b0;
    logic [5:0]  ld_addr = 6'd0;
    logic [31:0] ld_data = 32'd0;

    always @(posedge clock) begin
        if (ld_en)          mem[ld_addr] <= ld_data;
        else if (mem_write) mem[address[5:0]] <= write_data;
        if (mem_read)       rdata <= mem[address[5:0]];
    end
    assign read_data = rdata;

    // Bus monitor, sampled on the falling edge.
    int          cyc = 0;
    int          wr_count = 0;
    int          done_count = 0;
    logic [31:0] wr_addr [0:63];
    int          done_cyc [0:7];
    bit          both_seen = 1'b0;
    bit          dirty = 1'b0;

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (mem_read && mem_write) both_seen <= 1'b1;
        if (!mem_write && write_data != 32'd0) dirty <= 1'b1;
        if (!mem_read && !mem_write && address != 32'd0) dirty <= 1'b1;
        if (mem_write) begin
            wr_addr[wr_count[5:0]] <= address;
            wr_count <= wr_count + 1;
        end
        if (done) begin
            done_cyc[done_count[2:0]] <= cyc;
            done_count <= done_count + 1;
        end
    end

    logic [31:0] s1_a [9] = '{6, 2, 3, 5, 5, 4, 5, 6, 5};
    logic [31:0] s1_b [9] = '{7, 2, 2, 5, 2, 5, 3, 5, 8};
    logic [31:0] s1_c [9] = '{61, 31, 46, 72, 40, 67, 80, 47, 80};
    logic [31:0] id_a [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    logic [31:0] s2_b [9] = '{11, 22, 33, 44, 55, 66, 77, 88, 99};

    task automatic load_image(input logic [31:0] a_m [9], input logic [31:0] b_m [9]);
        for (int x = 0; x < 27; x++) begin
            @(negedge clock);
            ld_en   = 1'b1;
            ld_addr = 6'(x);
            if (x < 9)       ld_data = a_m[x];
            else if (x < 18) ld_data = b_m[x - 9];
            else             ld_data = 32'hC0DE_0000 + 32'(x);
        end
        @(negedge clock);
        ld_en = 1'b0;
    endtask

    // Pulses start for one cycle and counts cycles until done (-1 on timeout).
    task automatic run_once(output int cycles);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cycles = 1;
        while (done !== 1'b1 && cycles < 300) begin
            @(negedge clock);
            cycles++;
        end
        if (done !== 1'b1) cycles = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL reset_rd: got %b want 0", mem_read); end
        n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL reset_wr: got %b want 0", mem_write); end
        n_cmp++; if (address !== 32'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", address); end
        n_cmp++; if (write_data !== 32'd0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", write_data); end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic();
        int c;
        int wc0;
        load_image(s1_a, s1_b);
        wc0 = wr_count;
        run_once(c);
        n_cmp++; if (c !== 91) begin n_bad++; $display("FAIL basic_latency: got %0d want 91", c); end
        @(negedge clock);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after: got %b want 0", busy); end
        @(negedge clock);
        for (int e = 0; e < 9; e++) begin
            n_cmp++;
            if (mem[18 + e] !== s1_c[e]) begin
                n_bad++; $display("FAIL basic_c%0d: got %0d want %0d", e, mem[18 + e], s1_c[e]);
            end
        end
        n_cmp++; if (wr_count - wc0 !== 9) begin n_bad++; $display("FAIL basic_writes: got %0d want 9", wr_count - wc0); end
    endtask

    task automatic test_identity();
        int c;
        int wc0;
        load_image(id_a, s2_b);
        wc0 = wr_count;
        run_once(c);
        repeat (2) @(negedge clock);
        n_cmp++; if (wr_count - wc0 !== 9) begin n_bad++; $display("FAIL ident_writes: got %0d want 9", wr_count - wc0); end
        for (int e = 0; e < 9; e++) begin
            n_cmp++;
            if (mem[18 + e] !== s2_b[e]) begin
                n_bad++; $display("FAIL ident_c%0d: got %0d want %0d", e, mem[18 + e], s2_b[e]);
            end
            n_cmp++;
            if (wr_addr[(wc0 + e) % 64] !== 32'(18 + e)) begin
                n_bad++; $display("FAIL ident_addr%0d: got %0d want %0d", e, wr_addr[(wc0 + e) % 64], 18 + e);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int c;
        load_image(s1_a, s1_b);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        c = 1;
        while (c < 39) begin @(negedge clock); c++; end
        // Cycle 39 of the run is the final ACC of element (1,0): no strobe, still busy.
        n_cmp++;
        if ({busy, mem_read, mem_write} !== 3'b100) begin
            n_bad++; $display("FAIL midrun_acc_state: got %b want 100", {busy, mem_read, mem_write});
        end
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({busy, done, mem_read, mem_write, address, write_data} !== 68'd0) begin
            n_bad++; $display("FAIL midrun_outputs: got %h want 0", {busy, done, mem_read, mem_write, address, write_data});
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        for (int e = 0; e < 9; e++) begin
            n_cmp++;
            if (e < 3 && mem[18 + e] !== s1_c[e]) begin
                n_bad++; $display("FAIL midrun_kept%0d: got %0d want %0d", e, mem[18 + e], s1_c[e]);
            end else if (e >= 3 && mem[18 + e] !== 32'hC0DE_0000 + 32'(18 + e)) begin
                n_bad++; $display("FAIL midrun_untouched%0d: got %h want %h", e, mem[18 + e], 32'hC0DE_0000 + 32'(18 + e));
            end
        end
        run_once(c);
        n_cmp++; if (c !== 91) begin n_bad++; $display("FAIL midrun_rerun_latency: got %0d want 91", c); end
        repeat (2) @(negedge clock);
        for (int e = 0; e < 9; e++) begin
            n_cmp++;
            if (mem[18 + e] !== s1_c[e]) begin
                n_bad++; $display("FAIL midrun_rerun_c%0d: got %0d want %0d", e, mem[18 + e], s1_c[e]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int c;
        int wc0;
        int dc0;
        load_image(id_a, s2_b);
        wc0 = wr_count;
        dc0 = done_count;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        c = 1;
        while (done !== 1'b1 && c < 300) begin
            @(negedge clock);
            c++;
            start = (c == 5);
        end
        n_cmp++; if (c !== 91) begin n_bad++; $display("FAIL ignore_latency: got %0d want 91", c); end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_done_start: got busy=%b want 0", busy); end
        repeat (5) @(negedge clock);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_still_idle: got busy=%b want 0", busy); end
        n_cmp++; if (wr_count - wc0 !== 9) begin n_bad++; $display("FAIL ignore_writes: got %0d want 9", wr_count - wc0); end
        n_cmp++; if (done_count - dc0 !== 1) begin n_bad++; $display("FAIL ignore_dones: got %0d want 1", done_count - dc0); end
    endtask

    task automatic test_overflow();
        int c;
        logic [31:0] a_m [9];
        logic [31:0] b_m [9];
        for (int x = 0; x < 9; x++) begin
            a_m[x] = (x < 3) ? 32'hFFFF_FFFF : 32'd0;
            b_m[x] = (x % 3 == 0) ? 32'hFFFF_FFFF : 32'd0;
        end
        load_image(a_m, b_m);
        run_once(c);
        repeat (2) @(negedge clock);
        n_cmp++; if (mem[18] !== 32'h0000_0003) begin n_bad++; $display("FAIL ovf_c00: got %h want 00000003", mem[18]); end
        n_cmp++; if (mem[22] !== 32'd0) begin n_bad++; $display("FAIL ovf_c11: got %h want 00000000", mem[22]); end
    endtask

    task automatic test_back_to_back();
        int dc0;
        int k;
        load_image(s1_a, s1_b);
        dc0 = done_count;
        @(negedge clock);
        start = 1'b1;
        repeat (200) @(negedge clock);
        start = 1'b0;
        n_cmp++; if (done_count - dc0 !== 2) begin n_bad++; $display("FAIL b2b_runs: got %0d want 2", done_count - dc0); end
        // DONE -> IDLE (samples start) -> RD_A: pulses 92 edges apart, 91 cycles between them.
        n_cmp++;
        if (done_cyc[(dc0 + 1) % 8] - done_cyc[dc0 % 8] !== 92) begin
            n_bad++; $display("FAIL b2b_gap: got %0d want 92", done_cyc[(dc0 + 1) % 8] - done_cyc[dc0 % 8]);
        end
        k = 0;
        while (busy === 1'b1 && k < 200) begin @(negedge clock); k++; end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_timeout: got busy=%b want 0", busy); end
        @(negedge clock);
        n_cmp++; if (both_seen !== 1'b0) begin n_bad++; $display("FAIL rd_wr_exclusive: got %b want 0", both_seen); end
        n_cmp++; if (dirty !== 1'b0) begin n_bad++; $display("FAIL idle_bus_zero: got %b want 0", dirty); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_identity();
        test_reset_midrun();
        test_ignore_start();
        test_overflow();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
